// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types and defaults for the instruction memory
package inst_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    LD_HDR  = 2'd0,
    LD_BODY = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_e;

  typedef enum logic {
    FE_IDLE = 1'b0,
    FE_RESP = 1'b1
  } fe_state_e;

endpackage

// File: rtl/inst_ram.sv
// rtl/inst_ram.sv - single-port 32-bit synchronous RAM, one-cycle read latency
module inst_ram
  import inst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  // Array write and registered read; the read register holds between reads
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_memory.sv
// rtl/inst_memory.sv - byte-stream loaded instruction memory with fetch port
module inst_memory
  import inst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  output logic        loaded,
  input  logic [31:0] req_addr,
  input  logic        req_valid,
  output logic [31:0] resp_data,
  output logic        resp_ready
);

  ld_state_e             r_ld_state, w_ld_next;
  fe_state_e             r_fe_state, w_fe_next;
  logic [1:0]            r_byte_idx, w_byte_idx_next;
  logic [31:0]           r_header, w_header_next;
  logic [23:0]           r_asm, w_asm_next;
  logic [ADDR_WIDTH-1:0] r_wptr, w_wptr_next;
  logic [31:0]           r_remaining, w_remaining_next;
  logic [31:0]           r_resp_data;
  logic [31:0]           w_new_n;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [31:0]           w_ram_wdata;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_rdata;
  logic                  w_unused_addr_bits;

  // Byte offset and out-of-range address bits are deliberately dropped
  assign w_unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  // Writes happen only while loading and reads only in RUN, so one port suffices
  assign w_ram_addr = (r_ld_state == LD_RUN) ? req_addr[ADDR_WIDTH+1:2] : r_wptr;

  inst_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // State registers for both FSMs and the load datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_state  <= LD_HDR;
      r_fe_state  <= FE_IDLE;
      r_byte_idx  <= 2'd0;
      r_header    <= 32'd0;
      r_asm       <= 24'd0;
      r_wptr      <= '0;
      r_remaining <= 32'd0;
    end else begin
      r_ld_state  <= w_ld_next;
      r_fe_state  <= w_fe_next;
      r_byte_idx  <= w_byte_idx_next;
      r_header    <= w_header_next;
      r_asm       <= w_asm_next;
      r_wptr      <= w_wptr_next;
      r_remaining <= w_remaining_next;
    end
  end

  // Load FSM: gather a little-endian header, then little-endian words into RAM
  always_comb begin
    w_ld_next        = r_ld_state;
    w_byte_idx_next  = r_byte_idx;
    w_header_next    = r_header;
    w_asm_next       = r_asm;
    w_wptr_next      = r_wptr;
    w_remaining_next = r_remaining;
    w_ram_we         = 1'b0;
    w_ram_wdata      = {load_data, r_asm};
    w_new_n          = {load_data, r_header[23:0]};
    case (r_ld_state)
      LD_HDR: begin
        if (load_valid) begin
          w_byte_idx_next = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0: w_header_next[7:0]   = load_data;
            2'd1: w_header_next[15:8]  = load_data;
            2'd2: w_header_next[23:16] = load_data;
            default: begin
              w_header_next[31:24] = load_data;
              if (w_new_n == 32'd0) begin
                w_ld_next = LD_RUN;
              end else begin
                w_ld_next        = LD_BODY;
                w_wptr_next      = '0;
                w_remaining_next = w_new_n;
              end
            end
          endcase
        end
      end
      LD_BODY: begin
        if (load_valid) begin
          w_byte_idx_next = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0: w_asm_next[7:0]   = load_data;
            2'd1: w_asm_next[15:8]  = load_data;
            2'd2: w_asm_next[23:16] = load_data;
            default: begin
              w_ram_we         = 1'b1;
              w_wptr_next      = r_wptr + ADDR_WIDTH'(1);
              w_remaining_next = r_remaining - 32'd1;
              if (r_remaining == 32'd1) begin
                w_ld_next = LD_RUN;
              end
            end
          endcase
        end
      end
      LD_RUN:  w_ld_next = LD_RUN;
      default: w_ld_next = LD_HDR;
    endcase
  end

  // Fetch FSM: accept a request only once loaded, respond exactly one cycle later
  always_comb begin
    w_fe_next = r_fe_state;
    w_ram_re  = 1'b0;
    case (r_fe_state)
      FE_IDLE: begin
        if ((r_ld_state == LD_RUN) && req_valid) begin
          w_ram_re  = 1'b1;
          w_fe_next = FE_RESP;
        end
      end
      FE_RESP: w_fe_next = FE_IDLE;
      default: w_fe_next = FE_IDLE;
    endcase
  end

  // Capture the word shown during the pulse so it stays visible afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_data <= 32'd0;
    end else if (r_fe_state == FE_RESP) begin
      r_resp_data <= w_ram_rdata;
    end
  end

  assign loaded     = (r_ld_state == LD_RUN);
  assign resp_ready = (r_fe_state == FE_RESP);
  assign resp_data  = resp_ready ? w_ram_rdata : r_resp_data;

endmodule
